// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral exposing a bank of read/write registers
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         ncs,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         addr_err
);

    localparam int F     = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(F + 1);
    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    logic sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic ncs_s1_q, ncs_s2_q, ncs_d_q;
    logic copi_s1_q, copi_s2_q;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [F-2:0]                 shift_q, shift_d;
    logic                         rw_q, rw_d;
    logic [DATA_W-1:0]            tx_q, tx_d;
    logic                         cipo_q, cipo_d;
    logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]          wr_strobe_q, wr_strobe_d;
    logic                         addr_err_q, addr_err_d;

    logic               sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [F-2:0]       shift_next;
    logic [ADDR_W-1:0]  hdr_addr, cmt_addr;
    logic               hdr_rw, hdr_ok, cmt_ok;
    logic [DATA_W-1:0]  rd_data;

    // Idle levels: sclk low, copi low, ncs deasserted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_d_q <= 1'b0;
            ncs_s1_q  <= 1'b1; ncs_s2_q  <= 1'b1; ncs_d_q  <= 1'b1;
            copi_s1_q <= 1'b0; copi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= sclk;     sclk_s2_q <= sclk_s1_q; sclk_d_q <= sclk_s2_q;
            ncs_s1_q  <= ncs;      ncs_s2_q  <= ncs_s1_q;  ncs_d_q  <= ncs_s2_q;
            copi_s1_q <= copi;     copi_s2_q <= copi_s1_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_d_q;
    assign sclk_fall = ~sclk_s2_q & sclk_d_q;
    assign ncs_rise  = ncs_s2_q & ~ncs_d_q;
    assign ncs_fall  = ~ncs_s2_q & ncs_d_q;

    // The shift register omits the final bit; it is taken straight from copi at commit
    assign shift_next = {shift_q[F-3:0], copi_s2_q};
    assign hdr_addr   = shift_next[ADDR_W-1:0];
    assign hdr_rw     = shift_next[ADDR_W];
    assign hdr_ok     = {1'b0, hdr_addr} < NUM_REGS_X;
    assign cmt_addr   = shift_next[F-2 -: ADDR_W];
    assign cmt_ok     = {1'b0, cmt_addr} < NUM_REGS_X;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr == ADDR_W'(k)) rd_data = regs_q[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        tx_d        = tx_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        addr_err_d  = 1'b0;

        if (ncs_rise) begin
            state_d = IDLE;
        end else if (ncs_fall) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            cipo_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (sclk_rise) begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                            state_d = DATA;
                            rw_d    = hdr_rw;
                            if (!hdr_rw) begin
                                tx_d       = rd_data;
                                addr_err_d = ~hdr_ok;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(F - 1)) begin
                            state_d = DONE;
                            if (shift_q[F-2]) begin
                                addr_err_d = ~cmt_ok;
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (cmt_addr == ADDR_W'(k)) begin
                                        regs_d[k*DATA_W +: DATA_W] = shift_next[DATA_W-1:0];
                                        wr_strobe_d[k] = 1'b1;
                                    end
                                end
                            end
                        end
                    end else if (sclk_fall && !rw_q) begin
                        cipo_d = tx_q[DATA_W-1];
                        tx_d   = tx_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            tx_q        <= '0;
            cipo_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            tx_q        <= tx_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign cipo      = cipo_q & (state_q == DATA) & ~rw_q;
    assign cipo_oe   = ~ncs_s2_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - self-checking bench for spi_reg_bank with default parameters
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        copi = 1'b0;
    logic        ncs = 1'b1;
    logic        cipo, cipo_oe, addr_err;
    logic [39:0] regs_flat;
    logic [4:0]  wr_strobe;

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        int         extra;
        logic [4:0] exp_strobe;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct packed {
        logic [4:0] strobe;
        logic       err;
    } ev_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  exp_q[$];
    ev_t  mon_ev;
    logic [7:0] model [5];
    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string name);
        logic [39:0] exp_flat;
        for (int k = 0; k < 5; k++) exp_flat[k*8 +: 8] = model[k];
        check(name, {24'h0, regs_flat}, {24'h0, exp_flat});
    endtask

    always @(negedge clk) begin
        if (rst_n && (wr_strobe != 5'b0 || addr_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: strobe=%b addr_err=%b expected none at %0t",
                         wr_strobe, addr_err, $time);
            end else begin
                mon_ev = exp_q.pop_front();
                check("wr_strobe", {59'h0, wr_strobe}, {59'h0, mon_ev.strobe});
                check("addr_err", {63'h0, addr_err}, {63'h0, mon_ev.err});
            end
        end
    end

    task automatic spi_bit(input logic b, input logic exp_cipo, input string name);
        copi = b;
        #60;
        check(name, {63'h0, cipo}, {63'h0, exp_cipo});
        sclk = 1'b1;
        #60;
        sclk = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        logic [15:0] bits;
        logic [7:0]  rdv;
        logic        b, ecipo;
        ev_t         e;
        bits = {v.rw, v.addr, v.data};
        rdv  = v.exp_rd;
        if (v.exp_strobe != 5'b0 || v.exp_err) begin
            e.strobe = v.exp_strobe;
            e.err    = v.exp_err;
            exp_q.push_back(e);
        end
        ncs = 1'b0;
        #60;
        check("cipo_oe_active", {63'h0, cipo_oe}, 64'h1);
        for (int i = 0; i < v.nbits + v.extra; i++) begin
            b     = (i < 16) ? bits[15-i] : 1'b1;
            ecipo = (!v.rw && i >= 8 && i < 16) ? rdv[15-i] : 1'b0;
            spi_bit(b, ecipo, "cipo");
        end
        #60;
        ncs = 1'b1;
        #120;
        check("events_drained", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        if (v.rw && v.nbits == 16 && v.addr < 7'd5) model[v.addr[2:0]] = v.data;
        check_regs("regs_flat");
        check("cipo_oe_idle", {63'h0, cipo_oe}, 64'h0);
    endtask

    initial begin
        logic [15:0] rbits;
        vec_t        v;

        vecs[0]  = '{1'b1, 7'h02, 8'hA5, 16, 0, 5'b00100, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 7'h07, 8'hFF, 16, 0, 5'b00000, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 7'h02, 8'h00, 16, 0, 5'b00000, 1'b0, 8'hA5};
        vecs[3]  = '{1'b1, 7'h04, 8'h3C, 12, 0, 5'b00000, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 7'h04, 8'h3C, 16, 0, 5'b10000, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 7'h00, 8'h5A, 16, 4, 5'b00001, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 7'h04, 8'h00, 16, 0, 5'b00000, 1'b0, 8'h3C};
        vecs[7]  = '{1'b0, 7'h06, 8'h00, 16, 0, 5'b00000, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 7'h7F, 8'h11, 16, 0, 5'b00000, 1'b1, 8'h00};
        vecs[9]  = '{1'b1, 7'h01, 8'hC3, 16, 0, 5'b00010, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 7'h00, 8'h00, 16, 0, 5'b00000, 1'b0, 8'h5A};
        for (int k = 0; k < 5; k++) model[k] = 8'h00;

        repeat (4) @(negedge clk);
        check("rst_regs", {24'h0, regs_flat}, 64'h0);
        check("rst_strobe", {59'h0, wr_strobe}, 64'h0);
        check("rst_addr_err", {63'h0, addr_err}, 64'h0);
        check("rst_cipo", {63'h0, cipo}, 64'h0);
        check("rst_cipo_oe", {63'h0, cipo_oe}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_cipo_oe_0", {63'h0, cipo_oe}, 64'h0);
        @(negedge clk);
        check("rel_cipo_oe_1", {63'h0, cipo_oe}, 64'h0);
        #100;

        for (int n = 0; n < 11; n++) run_frame(vecs[n]);

        // Reset lands after 10 bits of a write to reg 1; the frame must vanish
        rbits = {1'b1, 7'h01, 8'h81};
        ncs = 1'b0;
        #60;
        for (int i = 0; i < 10; i++) spi_bit(rbits[15-i], 1'b0, "cipo_pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_regs", {24'h0, regs_flat}, 64'h0);
        check("mid_rst_strobe", {59'h0, wr_strobe}, 64'h0);
        check("mid_rst_addr_err", {63'h0, addr_err}, 64'h0);
        check("mid_rst_cipo", {63'h0, cipo}, 64'h0);
        check("mid_rst_cipo_oe", {63'h0, cipo_oe}, 64'h0);
        ncs  = 1'b1;
        copi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        @(negedge clk);
        check("post_rst_cipo_oe_0", {63'h0, cipo_oe}, 64'h0);
        @(negedge clk);
        check("post_rst_cipo_oe_1", {63'h0, cipo_oe}, 64'h0);
        #100;
        check_regs("post_rst_regs");

        v = '{1'b1, 7'h01, 8'h81, 16, 0, 5'b00010, 1'b0, 8'h00};
        run_frame(v);
        v = '{1'b0, 7'h01, 8'h00, 16, 0, 5'b00000, 1'b0, 8'h81};
        run_frame(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
